// File: rtl/muxn_pipe_pkg.sv
// Shared constants for the N-way registered mux: skid-buffer state encodings
// and select-width helper used by the datapath mux blocks.
package muxn_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned MUXN_MIN_SEL_W = 1;

  // Select width for n channels; never narrower than one bit.
  function automatic int unsigned muxn_sel_width(input int unsigned n);
    return (n < 2) ? MUXN_MIN_SEL_W : $clog2(n);
  endfunction

endpackage

// File: rtl/muxn_sel.sv
// Combinational channel select with range check; out-of-range selects
// produce an all-zero word flagged by err.
module muxn_sel
  import muxn_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 2,
  localparam int unsigned SEL_W = muxn_sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);

  // Pick channel sel; if no channel matches, the word stays zero and err stays set.
  always_comb begin
    word = '0;
    err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way mux followed by a 2-entry skid buffer. in_ready and out_valid are
// flops so neither depends combinationally on in_valid or out_ready.
module muxn_pipe
  import muxn_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 2,
  localparam int unsigned SEL_W = muxn_sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  skid_state_t      state, state_nx;
  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             accept, transfer;
  logic             load_out, load_skid, out_from_skid;

  muxn_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .word    (sel_word),
    .err     (sel_err)
  );

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // Next state and register load controls for the skid buffer.
  always_comb begin
    state_nx      = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nx = ST_HALF;
          load_out = 1'b1;
        end
      end
      ST_HALF: begin
        case ({accept, transfer})
          2'b11: load_out = 1'b1;
          2'b10: begin
            state_nx  = ST_FULL;
            load_skid = 1'b1;
          end
          2'b01: state_nx = ST_EMPTY;
          default: state_nx = ST_HALF;
        endcase
      end
      ST_FULL: begin
        if (transfer) begin
          state_nx      = ST_HALF;
          out_from_skid = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  // State, handshake flops and data registers; handshake flops follow state_nx
  // so they always agree with the state they encode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel_err <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != ST_FULL);
      out_valid <= (state_nx != ST_EMPTY);
      if (load_out) begin
        out_data    <= sel_word;
        out_sel_err <= sel_err;
      end else if (out_from_skid) begin
        out_data    <= skid_data;
        out_sel_err <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_word;
        skid_err  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: directed literal checks on two small configurations and
// a queue-based model compared every cycle on an 8-bit, 4-channel instance.
module tb_muxn_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: WIDTH=5, NUM_IN=2
  logic [9:0] a_in_data;
  logic [0:0] a_sel;
  logic       a_in_valid, a_in_ready, a_out_ready, a_out_valid, a_err;
  logic [4:0] a_out_data;

  muxn_pipe #(.WIDTH(5), .NUM_IN(2)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel_err(a_err), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  // Instance B: WIDTH=5, NUM_IN=3
  logic [14:0] b_in_data;
  logic [1:0]  b_sel;
  logic        b_in_valid, b_in_ready, b_out_ready, b_out_valid, b_err;
  logic [4:0]  b_out_data;

  muxn_pipe #(.WIDTH(5), .NUM_IN(3)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel_err(b_err), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  // Instance C: WIDTH=8, NUM_IN=4, checked against the model
  localparam int C_N = 4;
  logic [31:0] c_in_data;
  logic [1:0]  c_sel;
  logic        c_in_valid, c_in_ready, c_out_ready, c_out_valid, c_err;
  logic [7:0]  c_out_data;

  muxn_pipe #(.WIDTH(8), .NUM_IN(C_N)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .sel(c_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_sel_err(c_err), .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  // Model: a FIFO of at most two words; ready while fewer than two are held,
  // valid while any is held, output is the oldest word.
  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } word_t;

  word_t       mq[$];
  int unsigned m_acc = 0;
  int unsigned m_del = 0;
  logic        m_take, m_give;
  word_t       m_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_take = c_in_valid && (mq.size() < 2);
      m_give = c_out_ready && (mq.size() > 0);
      m_w.e  = (int'(c_sel) >= C_N);
      m_w.d  = m_w.e ? 8'h00 : c_in_data[int'(c_sel)*8 +: 8];
      if (m_give) begin
        void'(mq.pop_front());
        m_del++;
      end
      if (m_take) begin
        mq.push_back(m_w);
        m_acc++;
      end
    end
  end

  // Compare instance C with the model once per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("c_in_ready", c_in_ready, mq.size() < 2);
      check("c_out_valid", c_out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("c_out_data", c_out_data, mq[0].d);
        check("c_out_err", c_err, mq[0].e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    #12;
    check("rst_a_in_ready", a_in_ready, 1'b1);
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_out_data", a_out_data, 5'h00);
    check("rst_a_err", a_err, 1'b0);

    // Offer a word across an edge while reset is held: it must not be taken.
    a_in_valid = 1'b1; a_sel = 1'b0; a_in_data = {5'h00, 5'h07};
    tick();
    rst = 1'b0;
    a_in_valid = 1'b0;
    check("rst_no_accept", a_out_valid, 1'b0);

    // Single word, one-cycle latency; first edge after reset.
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_sel = 1'b1; a_in_data = {5'h1A, 5'h03};
    tick();
    check("lat1_valid", a_out_valid, 1'b1);
    check("lat1_data", a_out_data, 5'h1A);
    check("lat1_err", a_err, 1'b0);
    check("lat1_ready", a_in_ready, 1'b1);
    a_in_valid = 1'b0; a_in_data = 'x; a_sel = 'x;
    tick();
    check("drain_valid", a_out_valid, 1'b0);

    // Stall: two words fill the buffer, third offer is refused.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_sel = 1'b0; a_in_data = {5'h1F, 5'h01};
    tick();
    check("st1_valid", a_out_valid, 1'b1);
    check("st1_data", a_out_data, 5'h01);
    check("st1_ready", a_in_ready, 1'b1);
    a_in_data = {5'h1F, 5'h02};
    tick();
    check("st2_ready", a_in_ready, 1'b0);
    check("st2_data", a_out_data, 5'h01);
    a_in_data = {5'h1F, 5'h03};
    tick();
    check("st3_ready", a_in_ready, 1'b0);
    check("st3_data", a_out_data, 5'h01);
    a_in_valid = 1'b0; a_in_data = 'x; a_sel = 'x;
    a_out_ready = 1'b1;
    tick();
    check("un1_data", a_out_data, 5'h02);
    check("un1_valid", a_out_valid, 1'b1);
    check("un1_ready", a_in_ready, 1'b1);
    tick();
    check("un2_valid", a_out_valid, 1'b0);

    // Fill, then reset asynchronously between edges.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_sel = 1'b0; a_in_data = {5'h00, 5'h0A};
    tick();
    a_in_data = {5'h00, 5'h0B};
    tick();
    check("full_ready", a_in_ready, 1'b0);
    a_in_valid = 1'b0; a_in_data = 'x; a_sel = 'x;
    #3 rst = 1'b1;
    #1;
    check("arst_valid", a_out_valid, 1'b0);
    check("arst_ready", a_in_ready, 1'b1);
    check("arst_data", a_out_data, 5'h00);
    check("arst_err", a_err, 1'b0);
    #2 rst = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check("post_rst_valid0", a_out_valid, 1'b0);
    tick();
    check("post_rst_valid1", a_out_valid, 1'b0);
    a_in_valid = 1'b1; a_sel = 1'b0; a_in_data = {5'h00, 5'h0C};
    tick();
    check("post_rst_data", a_out_data, 5'h0C);
    a_in_valid = 1'b0; a_in_data = 'x; a_sel = 'x;
    tick();

    // Out-of-range select on three channels, then back-to-back words.
    b_in_valid = 1'b1; b_sel = 2'd3; b_in_data = {5'h11, 5'h12, 5'h13};
    tick();
    check("oor_data", b_out_data, 5'h00);
    check("oor_err", b_err, 1'b1);
    check("oor_valid", b_out_valid, 1'b1);
    b_sel = 2'd2;
    tick();
    check("b_sel2_data", b_out_data, 5'h11);
    check("b_sel2_err", b_err, 1'b0);
    check("b_thru_ready", b_in_ready, 1'b1);
    b_sel = 2'd0;
    tick();
    check("b_sel0_data", b_out_data, 5'h13);
    b_in_valid = 1'b0; b_in_data = 'x; b_sel = 'x;
    tick();
    check("b_drain_valid", b_out_valid, 1'b0);

    // Pin the model with literal values on instance C.
    c_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_data = 32'h4433_2211; c_sel = 2'd2;
    tick();
    check("c_pin1_data", c_out_data, 8'h33);
    check("c_pin1_model", mq[0].d, 8'h33);
    c_sel = 2'd3;
    tick();
    check("c_pin2_ready", c_in_ready, 1'b0);
    check("c_pin2_model", mq.size(), 2);
    c_in_valid = 1'b0; c_in_data = 'x; c_sel = 'x;
    c_out_ready = 1'b1;
    tick();
    check("c_pin3_data", c_out_data, 8'h44);
    tick();
    check("c_pin4_valid", c_out_valid, 1'b0);

    // Random traffic: 50% in_valid / out_ready, 1000 words.
    m_acc = 0;
    m_del = 0;
    for (int cyc = 0; cyc < 20000 && m_del < 1000; cyc++) begin
      @(posedge clk);
      #2;
      c_in_valid  = (m_acc < 1000) && ($urandom_range(0, 1) == 1);
      c_out_ready = ($urandom_range(0, 1) == 1);
      if (c_in_valid) begin
        c_in_data = $urandom;
        c_sel     = 2'($urandom_range(0, 3));
      end else begin
        c_in_data = 'x;
        c_sel     = 'x;
      end
    end
    c_in_valid = 1'b0;
    tick();
    check("c_words_accepted", m_acc, 1000);
    check("c_words_delivered", m_del, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
